host_uart_rsp_serializer: RTL and testbench

Downstream stage of the host UART response encoder. It accepts one fully built response frame (a wide parallel vector, byte 0 = response ID), determines the frame length from the ID, and streams the frame LSB-byte-first to the UART transmitter over a valid/ready byte handshake. It optionally appends an XOR checksum byte, then reports completion or error.

---
 rtl/host_uart_pkg.sv | 20 ++
 rtl/host_uart_rsp_serializer_if.sv | 26 ++
 rtl/host_uart_rsp_len_lut.sv | 30 +++
 rtl/host_uart_rsp_serializer.sv | 164 ++++++++++++++++
 tb/tb_host_uart_rsp_serializer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/host_uart_pkg.sv
// Shared constants and types for the host UART response path.
package host_uart_pkg;

    localparam int unsigned LEN_W = 8;

    localparam logic [7:0] RSP_ID_ENCRYPT_ENABLE = 8'h02;
    localparam logic [7:0] RSP_ID_READ_YAW       = 8'h04;

    localparam logic [LEN_W-1:0] RSP_LEN_ENCRYPT_ENABLE = 8'd8;
    localparam logic [LEN_W-1:0] RSP_LEN_READ_YAW       = 8'd12;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        SEND,
        CHK,
        DONE
    } rsp_state_e;

endpackage

// File: rtl/host_uart_rsp_serializer_if.sv
// Frame-in / byte-out handshake bundle of the response serializer.
interface host_uart_rsp_serializer_if #(
    parameter int unsigned FRAME_W = 1025
);
    logic [FRAME_W-1:0] frame_in;
    logic               frame_valid;
    logic               frame_ready;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;
    logic               done;
    logic               error;

    // Upstream encoder / UART side drives frames and tx_ready.
    modport master (
        output frame_in, frame_valid, tx_ready,
        input  frame_ready, tx_data, tx_valid, busy, done, error
    );

    // Serializer side.
    modport slave (
        input  frame_in, frame_valid, tx_ready,
        output frame_ready, tx_data, tx_valid, busy, done, error
    );
endinterface

// File: rtl/host_uart_rsp_len_lut.sv
// Response ID to frame length table; combinational, shared with the command decoder.
module host_uart_rsp_len_lut
    import host_uart_pkg::*;
(
    input  logic [7:0]       rsp_id_i,
    output logic [LEN_W-1:0] rsp_len_c_o,
    output logic             known_c_o
);

    // Decode the ID; unknown IDs report length 0.
    always_comb begin
        rsp_len_c_o = '0;
        known_c_o   = 1'b0;
        unique case (rsp_id_i)
            RSP_ID_ENCRYPT_ENABLE: begin
                rsp_len_c_o = RSP_LEN_ENCRYPT_ENABLE;
                known_c_o   = 1'b1;
            end
            RSP_ID_READ_YAW: begin
                rsp_len_c_o = RSP_LEN_READ_YAW;
                known_c_o   = 1'b1;
            end
            default: begin
                rsp_len_c_o = '0;
                known_c_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/host_uart_rsp_serializer.sv
// Streams a parallel response frame LSB-byte-first over a byte valid/ready
// handshake, with an optional XOR checksum trailer.
module host_uart_rsp_serializer
    import host_uart_pkg::*;
#(
    parameter int unsigned FRAME_W     = 1025,
    parameter int unsigned MAX_BYTES   = 128,
    parameter bit          CHECKSUM_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    host_uart_rsp_serializer_if.slave   bus
);

    localparam int unsigned IDX_W  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int unsigned HOLD_W = 8 * MAX_BYTES;

    rsp_state_e                  state_q, state_d;
    logic [MAX_BYTES-1:0][7:0]   hold_q;
    logic                        hold_load;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [LEN_W-1:0]            len_q, len_d;
    logic [7:0]                  cks_q, cks_d;
    logic [7:0]                  tx_data_q, tx_data_d;
    logic                        tx_valid_q, tx_valid_d;
    logic                        frame_ready_q, frame_ready_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        error_q, error_d;

    logic [LEN_W-1:0]            lut_len;
    logic                        lut_known;
    logic                        tx_fire;
    logic                        last_byte;
    logic [IDX_W-1:0]            idx_next;

    // Frame bits above the longest frame are never transmitted.
    if (FRAME_W > HOLD_W) begin : g_unused_msbs
        logic unused_frame_msbs;
        assign unused_frame_msbs = ^bus.frame_in[FRAME_W-1:HOLD_W];
    end

    host_uart_rsp_len_lut u_len_lut (
        .rsp_id_i    (hold_q[0]),
        .rsp_len_c_o (lut_len),
        .known_c_o   (lut_known)
    );

    assign tx_fire   = tx_valid_q & bus.tx_ready;
    assign last_byte = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
    assign idx_next  = idx_q + IDX_W'(1);

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        hold_load = 1'b0;
        idx_d     = idx_q;
        len_d     = len_q;
        cks_d     = cks_q;
        tx_data_d = tx_data_q;
        error_d   = error_q;

        unique case (state_q)
            IDLE: begin
                if (bus.frame_valid && frame_ready_q) begin
                    hold_load = 1'b1;
                    error_d   = 1'b0;
                    cks_d     = 8'h00;
                    idx_d     = '0;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lut_known) begin
                    len_d     = lut_len;
                    tx_data_d = hold_q[0];
                    state_d   = SEND;
                end else begin
                    error_d = 1'b1;
                    state_d = DONE;
                end
            end
            SEND: begin
                if (tx_fire) begin
                    cks_d = cks_q ^ tx_data_q;
                    if (last_byte) begin
                        if (CHECKSUM_EN) begin
                            tx_data_d = cks_q ^ tx_data_q;
                            state_d   = CHK;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        idx_d     = idx_next;
                        tx_data_d = hold_q[idx_next];
                    end
                end
            end
            CHK: begin
                if (tx_fire) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_valid_d    = (state_d == SEND) || (state_d == CHK);
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
        frame_ready_d = (state_d == IDLE);
        if (!tx_valid_d) begin
            tx_data_d = 8'h00;
        end
    end

    // State and control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            cks_q         <= 8'h00;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            cks_q         <= cks_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            frame_ready_q <= frame_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    // Frame holding register, captured only on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
        end else if (hold_load) begin
            hold_q <= bus.frame_in[HOLD_W-1:0];
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;

endmodule

// File: tb/tb_host_uart_rsp_serializer.sv
// Directed bench for host_uart_rsp_serializer with a byte scoreboard.
module tb_host_uart_rsp_serializer;

    localparam int unsigned FW = 1025;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    host_uart_rsp_serializer_if #(.FRAME_W(FW)) bus ();

    host_uart_rsp_serializer #(
        .FRAME_W     (FW),
        .MAX_BYTES   (128),
        .CHECKSUM_EN (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         errors   = 0;
    int         checks   = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: length table, byte order and XOR trailer.
    function automatic void expect_frame(input logic [FW-1:0] f);
        int         len;
        logic [7:0] ck;
        ck = 8'h00;
        case (f[7:0])
            8'h02:   len = 8;
            8'h04:   len = 12;
            default: len = 0;
        endcase
        for (int k = 0; k < len; k++) begin
            exp_q.push_back(f[8*k +: 8]);
            ck ^= f[8*k +: 8];
        end
        if (len != 0) exp_q.push_back(ck);
    endfunction

    task automatic start_frame(input logic [FW-1:0] f);
        bus.frame_in    = f;
        bus.frame_valid = 1'b1;
        step();
        bus.frame_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done"}, 32'(bus.done), 32'd1);
    endtask

    // Byte monitor: scoreboard pop, stall stability, done pulse count.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(bus.tx_valid), 32'd1);
                check("stall_data", 32'(bus.tx_data), 32'(prev_data));
            end
            if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(bus.tx_data), 32'hxxxx_xxxx);
                end else begin
                    check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                end
            end
            if (bus.done === 1'b1) done_cnt++;
            prev_stall = (bus.tx_valid === 1'b1) && (bus.tx_ready !== 1'b1);
            prev_data  = bus.tx_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] fr_enc, fr_yaw, fr_bad, fr_other;
        int n;
        int dc0;

        fr_enc = '0;  fr_enc[7:0] = 8'h02; fr_enc[63:56] = 8'h01;
        fr_yaw = '0;  fr_yaw[7:0] = 8'h04; fr_yaw[87:56] = 32'h1122_3344;
        fr_bad = '0;  fr_bad[7:0] = 8'h07; fr_bad[15:8] = 8'h55;
        fr_other = '0; fr_other[7:0] = 8'h02; fr_other[31:8] = 24'hA5_5A_FF;

        reset = 1'b1;
        bus.frame_valid = 1'b0;
        bus.frame_in    = '0;
        bus.tx_ready    = 1'b1;
        repeat (3) step();

        // Reset values
        check("rst_frame_ready", 32'(bus.frame_ready), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        reset = 1'b0;
        step();
        check("ready_after_rst", 32'(bus.frame_ready), 32'd1);

        // Encrypt response, tx_ready held high
        dc0 = done_cnt;
        expect_frame(fr_enc);
        start_frame(fr_enc);
        check("enc_t1_busy", 32'(bus.busy), 32'd1);
        check("enc_t1_ready", 32'(bus.frame_ready), 32'd0);
        check("enc_t1_valid", 32'(bus.tx_valid), 32'd0);
        step();
        check("enc_t2_valid", 32'(bus.tx_valid), 32'd1);
        check("enc_t2_data", 32'(bus.tx_data), 32'h02);
        wait_done("enc", 40, n);
        check("enc_latency", 32'(n), 32'd9);
        check("enc_error", 32'(bus.error), 32'd0);
        step();
        check("enc_done_cnt", 32'(done_cnt), 32'(dc0 + 1));
        check("enc_q_empty", 32'(exp_q.size()), 32'd0);
        check("enc_ready_back", 32'(bus.frame_ready), 32'd1);
        check("enc_done_drop", 32'(bus.done), 32'd0);
        check("enc_busy_drop", 32'(bus.busy), 32'd0);

        // Yaw response
        dc0 = done_cnt;
        expect_frame(fr_yaw);
        start_frame(fr_yaw);
        step();
        check("yaw_t2_data", 32'(bus.tx_data), 32'h04);
        wait_done("yaw", 40, n);
        check("yaw_latency", 32'(n), 32'd13);
        step();
        check("yaw_done_cnt", 32'(done_cnt), 32'(dc0 + 1));
        check("yaw_q_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure on byte index 3
        dc0 = done_cnt;
        expect_frame(fr_enc);
        start_frame(fr_enc);
        repeat (4) step();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.tx_valid), 32'd1);
            check("bp_data", 32'(bus.tx_data), 32'h00);
            step();
        end
        bus.tx_ready = 1'b1;
        check("bp_q_left", 32'(exp_q.size()), 32'd6);
        wait_done("bp", 40, n);
        check("bp_latency", 32'(n), 32'd6);
        step();
        check("bp_done_cnt", 32'(done_cnt), 32'(dc0 + 1));
        check("bp_q_empty", 32'(exp_q.size()), 32'd0);

        // Unknown ID
        dc0 = done_cnt;
        start_frame(fr_bad);
        check("bad_t1_busy", 32'(bus.busy), 32'd1);
        step();
        check("bad_t2_error", 32'(bus.error), 32'd1);
        check("bad_t2_done", 32'(bus.done), 32'd1);
        check("bad_t2_valid", 32'(bus.tx_valid), 32'd0);
        step();
        check("bad_t3_ready", 32'(bus.frame_ready), 32'd1);
        check("bad_t3_error", 32'(bus.error), 32'd1);
        check("bad_done_cnt", 32'(done_cnt), 32'(dc0 + 1));
        expect_frame(fr_enc);
        start_frame(fr_enc);
        check("err_clear", 32'(bus.error), 32'd0);
        step();
        wait_done("after_bad", 40, n);
        step();
        check("after_bad_q", 32'(exp_q.size()), 32'd0);

        // frame_valid during SEND is ignored
        dc0 = done_cnt;
        expect_frame(fr_yaw);
        start_frame(fr_yaw);
        repeat (2) step();
        bus.frame_in    = fr_other;
        bus.frame_valid = 1'b1;
        check("busy_rej_ready", 32'(bus.frame_ready), 32'd0);
        repeat (2) step();
        bus.frame_valid = 1'b0;
        wait_done("busy_rej", 40, n);
        check("busy_rej_latency", 32'(n), 32'd10);
        repeat (5) step();
        check("busy_rej_done_cnt", 32'(done_cnt), 32'(dc0 + 1));
        check("busy_rej_q", 32'(exp_q.size()), 32'd0);
        check("busy_rej_idle", 32'(bus.busy), 32'd0);

        // Reset mid-stream after byte 4 of yaw
        expect_frame(fr_yaw);
        start_frame(fr_yaw);
        repeat (6) step();
        check("mid_q_left", 32'(exp_q.size()), 32'd8);
        dc0 = done_cnt;
        reset = 1'b1;
        #1;
        check("mid_valid", 32'(bus.tx_valid), 32'd0);
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_done", 32'(bus.done), 32'd0);
        check("mid_data", 32'(bus.tx_data), 32'd0);
        exp_q.delete();
        repeat (2) step();
        reset = 1'b0;
        step();
        check("mid_ready", 32'(bus.frame_ready), 32'd1);
        expect_frame(fr_enc);
        start_frame(fr_enc);
        step();
        check("mid_enc_first", 32'(bus.tx_data), 32'h02);
        wait_done("mid_enc", 40, n);
        check("mid_enc_latency", 32'(n), 32'd9);
        step();
        check("mid_done_cnt", 32'(done_cnt), 32'(dc0 + 1));
        check("mid_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
